mcb_frame_writer: RTL and testbench
===================================

Name: mcb_frame_writer

Overview:
Parametrised frame writer for one Spartan-6 MCB write port. Accepts a pixel word stream over valid/ready and packs it into fixed-length write bursts. Issues one write command per burst and tracks a frame pointer, ping-ponging between two frame buffers so the display reader always has a complete frame. Sits between the fractal pixel engine and the MCB user port; it supersedes the single-word port-0 controller.

Parameters:
DATA_W, 32, port data width in bits (32 or 64); bytes per word BPW = DATA_W/8.
BURST_LEN, 16, words per burst, 1..64; p_cmd_bl = BURST_LEN-1.
FRAME_WORDS, 76800, words per frame; must be a multiple of BURST_LEN (elaboration error otherwise).
ADDR_W, 30, MCB byte-address width.
FRAME0_BASE, 0, byte base of buffer 0; aligned to BURST_LEN*BPW.
FRAME1_BASE, 307200, byte base of buffer 1; same alignment rule.

Ports:
clk  in  1  system clock, same domain as MCB port clock
reset  in  1  asynchronous, active-high
calib_done  in  1  MCB calibration done, asynchronous; 2-flop synchronised internally
src_valid  in  1  pixel word valid
src_data  in  DATA_W  pixel word
src_ready  out  1  block accepts word this cycle
frame_sync  in  1  one-cycle pulse: restart the current frame at word 0
frame_done  out  1  one-cycle pulse: last burst command of a frame issued
write_buf  out  1  buffer currently being written
disp_buf  out  1  last completed buffer, for the reader
sync_abort  out  1  sticky: frame_sync arrived mid-frame; cleared by reset only
p_cmd_full  in  1  MCB cmd FIFO full
p_cmd_en  out  1  command strobe
p_cmd_instr  out  3  command instruction
p_cmd_bl  out  6  burst length minus 1
p_cmd_byte_addr  out  ADDR_W  burst byte address
p_wr_full  in  1  write FIFO full
p_wr_en  out  1  write strobe
p_wr_data  out  DATA_W  write data
p_wr_mask  out  DATA_W/8  byte mask; always 0

Behaviour:
- Reset values: all outputs 0; src_ready 0; state CALIB; word_ptr 0; beat count 0; write_buf 0; disp_buf 1; pending sync cleared.
- CALIB: src_ready 0. Go to FILL on the first cycle the synchronised calib_done is 1.
- FILL: src_ready = !p_wr_full (combinational from state and p_wr_full).
  - An accepted word (src_valid && src_ready) drives p_wr_en=1 and p_wr_data=src_data on the next cycle (1-cycle registered latency).
  - Beat count increments per accepted word; the cycle after the BURST_LEN-th accepted word, go to ISSUE.
- ISSUE: src_ready 0.
  - Hold while p_cmd_full=1.
  - When p_cmd_full=0: pulse p_cmd_en for exactly 1 cycle with p_cmd_instr=3'b000, p_cmd_bl=BURST_LEN-1, p_cmd_byte_addr = base(write_buf) + word_ptr*BPW, taken mod 2^ADDR_W.
  - The command never precedes the last p_wr_en of its burst; cmd_en is at least 1 cycle after the last wr_en.
  - Then go to ADVANCE.
- ADVANCE (1 cycle):
  - Pending sync: word_ptr = 0, no buffer swap, no frame_done.
  - Otherwise word_ptr += BURST_LEN. If that result equals FRAME_WORDS: word_ptr = 0, frame_done pulses, disp_buf = write_buf, write_buf toggles.
  - Clear beat count; go to FILL.
- frame_sync handling:
  - In FILL with beat count 0 and word_ptr 0: ignored.
  - In FILL with beat count 0 and word_ptr ≠ 0: word_ptr cleared immediately; sync_abort set.
  - Anywhere else (mid-burst, in ISSUE or in ADVANCE): latched as pending and applied in the next ADVANCE; sync_abort set. The partial burst is completed normally.
- frame_sync in CALIB: ignored.
- calib_done deasserting after CALIB: ignored.
- Simultaneous events: final burst plus pending sync → sync wins (no swap). Simultaneous p_wr_full rise and src_valid → no accept.
- Reset mid-burst: immediate return to reset values. Partially written FIFO data is discarded only by the MCB's own reset.

Optional Feature:
MCB_FRAME_DOUBLE_BUFFER_EN.
- Defined: ping-pong behaviour as above.
- Undefined: single buffer at FRAME0_BASE; write_buf and disp_buf tied 0; frame_done still pulses; FRAME1_BASE unused.

Decomposition:
- Package mcb_pkg: MCB instruction constants (WR=3'b000, RD=3'b001, WR_AP=3'b010, RD_AP=3'b011, REFRESH=3'b100); writer state enum (CALIB, FILL, ISSUE, ADVANCE); BPW helper function.
- One sub-module: bit_sync, a 2-flop synchroniser for calib_done, reused by the reader port.

Test Plan:
- Calib gating: calib_done held 0 for 50 cycles with src_valid=1 → src_ready 0 and no p_wr_en; calib_done=1 → src_ready rises exactly 3 cycles later (2 sync flops + 1 state transition).
- Single burst: BURST_LEN=16, 16 back-to-back words 0..15 → p_wr_en 16 cycles with data 0..15, one p_cmd_en with bl=15, addr=0; next burst addr=64.
- Backpressure: p_wr_full high for 5 cycles mid-burst, then p_cmd_full high 10 cycles → no words lost or duplicated; cmd_en issued 1 cycle after p_cmd_full falls.
- Frame wrap: FRAME_WORDS=64, BURST_LEN=16, stream 128 words → frame_done pulses after 4th and 8th command; 2nd frame addresses start at FRAME1_BASE; disp_buf 0 then 1.
- Mid-frame sync: frame_sync pulse on word 5 of burst 2 → burst completes at addr 64; next burst addr 0, same buffer, sync_abort=1, no frame_done.
- Async reset in ISSUE with p_cmd_full=1 → all outputs 0 immediately, state CALIB, write_buf 0.

Source files
------------

// File: rtl/mcb_pkg.sv
// -----------------------------------------------------------------------------
// mcb_pkg
// Shared definitions for the Spartan-6 MCB user-port blocks:
//   - MCB command instruction encodings
//   - frame writer state encoding
//   - bytes-per-word helper
// -----------------------------------------------------------------------------
package mcb_pkg;

  localparam logic [2:0] MCB_CMD_WR      = 3'b000;
  localparam logic [2:0] MCB_CMD_RD      = 3'b001;
  localparam logic [2:0] MCB_CMD_WR_AP   = 3'b010;
  localparam logic [2:0] MCB_CMD_RD_AP   = 3'b011;
  localparam logic [2:0] MCB_CMD_REFRESH = 3'b100;

  typedef enum logic [1:0] {
    WS_CALIB   = 2'd0,
    WS_FILL    = 2'd1,
    WS_ISSUE   = 2'd2,
    WS_ADVANCE = 2'd3
  } writer_state_e;

  // Bytes carried by one MCB data word.
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop synchroniser for a single slow level signal (e.g. MCB calib_done).
// Ports:
//   clk     in   destination clock
//   reset   in   asynchronous, active-high
//   i_async in   asynchronous level
//   o_sync  out  level synchronised to clk (2-cycle latency)
// -----------------------------------------------------------------------------
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: the synchroniser flops are reset too, so leaving reset always costs
  // the full 2-cycle latency before a held-high input is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/mcb_frame_writer.sv
// -----------------------------------------------------------------------------
// mcb_frame_writer
// Packs a valid/ready pixel word stream into fixed-length MCB write bursts,
// issues one WR command per burst and walks a frame pointer through a frame
// buffer. Optional ping-pong between two buffers.
//
// Build option: MCB_FRAME_DOUBLE_BUFFER_EN
//   defined   -> ping-pong between FRAME0_BASE and FRAME1_BASE
//   undefined -> single buffer at FRAME0_BASE, write_buf/disp_buf tied 0
//
// Ports:
//   clk, reset (async, active-high), calib_done (async, synchronised here)
//   src_valid/src_data/src_ready     pixel word stream in
//   frame_sync                       restart current frame at word 0
//   frame_done                       pulse: last command of a frame issued
//   write_buf/disp_buf               buffer being written / last complete
//   sync_abort                       sticky: frame_sync arrived mid-frame
//   p_cmd_*                          MCB command port
//   p_wr_*                           MCB write data port
// -----------------------------------------------------------------------------
module mcb_frame_writer
  import mcb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 76800,
  parameter int ADDR_W      = 30,
  parameter int FRAME0_BASE = 0,
  parameter int FRAME1_BASE = 307200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                calib_done,
  input  logic                src_valid,
  input  logic [DATA_W-1:0]   src_data,
  output logic                src_ready,
  input  logic                frame_sync,
  output logic                frame_done,
  output logic                write_buf,
  output logic                disp_buf,
  output logic                sync_abort,
  input  logic                p_cmd_full,
  output logic                p_cmd_en,
  output logic [2:0]          p_cmd_instr,
  output logic [5:0]          p_cmd_bl,
  output logic [ADDR_W-1:0]   p_cmd_byte_addr,
  input  logic                p_wr_full,
  output logic                p_wr_en,
  output logic [DATA_W-1:0]   p_wr_data,
  output logic [DATA_W/8-1:0] p_wr_mask
);

  localparam int BPW    = bytes_per_word(DATA_W);
  localparam int PTR_W  = $clog2(FRAME_WORDS + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  localparam logic [1:0] ST_CALIB   = 2'(WS_CALIB);
  localparam logic [1:0] ST_FILL    = 2'(WS_FILL);
  localparam logic [1:0] ST_ISSUE   = 2'(WS_ISSUE);
  localparam logic [1:0] ST_ADVANCE = 2'(WS_ADVANCE);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("mcb_frame_writer: DATA_W must be 32 or 64");
  end
  if (BURST_LEN < 1 || BURST_LEN > 64) begin : g_bad_burst
    $error("mcb_frame_writer: BURST_LEN must be 1..64");
  end
  if (FRAME_WORDS % BURST_LEN != 0) begin : g_bad_frame
    $error("mcb_frame_writer: FRAME_WORDS must be a multiple of BURST_LEN");
  end
  if ((FRAME0_BASE % (BURST_LEN * BPW)) != 0 ||
      (FRAME1_BASE % (BURST_LEN * BPW)) != 0) begin : g_bad_base
    $error("mcb_frame_writer: frame bases must be burst aligned");
  end

  logic [1:0]        r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [PTR_W-1:0]  r_word_ptr;
  logic              r_sync_pend;
  logic              r_sync_abort;
  logic              r_frame_done;
  logic              r_cmd_en;
  logic [5:0]        r_cmd_bl;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_calib;
  logic              w_accept;
  logic              w_last_beat;
  logic [PTR_W-1:0]  w_ptr_next;
  logic              w_frame_end;
  logic              w_swap;
  logic              w_write_buf;
  logic              w_disp_buf;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr;

  bit_sync u_calib_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (calib_done),
    .o_sync  (w_calib)
  );

  // Ready depends only on state and FIFO full, so a full rising in the same
  // cycle as src_valid blocks the accept.
  assign src_ready   = (r_state == ST_FILL) && !p_wr_full;
  assign w_accept    = src_valid && src_ready;
  assign w_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));
  assign w_ptr_next  = r_word_ptr + PTR_W'(BURST_LEN);
  assign w_frame_end = (w_ptr_next == PTR_W'(FRAME_WORDS));
  // A pending sync restarts the frame instead of completing it.
  assign w_swap      = (r_state == ST_ADVANCE) && !r_sync_pend && w_frame_end;
  assign w_addr      = w_base + ADDR_W'(r_word_ptr) * ADDR_W'(BPW);

`ifdef MCB_FRAME_DOUBLE_BUFFER_EN
  logic r_write_buf;
  logic r_disp_buf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_buf <= 1'b0;
      r_disp_buf  <= 1'b1;
    end else if (w_swap) begin
      r_disp_buf  <= r_write_buf;
      r_write_buf <= ~r_write_buf;
    end
  end

  assign w_write_buf = r_write_buf;
  assign w_disp_buf  = r_disp_buf;
  assign w_base      = r_write_buf ? ADDR_W'(FRAME1_BASE) : ADDR_W'(FRAME0_BASE);
`else
  assign w_write_buf = 1'b0;
  assign w_disp_buf  = 1'b0;
  assign w_base      = ADDR_W'(FRAME0_BASE);
`endif

  // NOTE: every register below is updated with non-blocking assignments so
  // that all of them see the pre-edge values of each other within the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_CALIB;
      r_beat       <= '0;
      r_word_ptr   <= '0;
      r_sync_pend  <= 1'b0;
      r_sync_abort <= 1'b0;
      r_frame_done <= 1'b0;
      r_cmd_en     <= 1'b0;
      r_cmd_bl     <= '0;
      r_cmd_addr   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
    end else begin
      r_cmd_en     <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_en      <= w_accept;
      if (w_accept) begin
        r_wr_data <= src_data;
      end

      case (r_state)
        ST_CALIB: begin
          if (w_calib) begin
            r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // Entered one cycle after the last accept, so the command always
          // trails the burst's final p_wr_en by at least one cycle.
          if (!p_cmd_full) begin
            r_cmd_en   <= 1'b1;
            r_cmd_bl   <= 6'(BURST_LEN - 1);
            r_cmd_addr <= w_addr;
            r_state    <= ST_ADVANCE;
          end
        end
        default: begin  // ST_ADVANCE
          if (r_sync_pend || w_frame_end) begin
            r_word_ptr <= '0;
          end else begin
            r_word_ptr <= w_ptr_next;
          end
          r_frame_done <= w_swap;
          r_sync_pend  <= 1'b0;
          r_beat       <= '0;
          r_state      <= ST_FILL;
        end
      endcase

      // Placed after the case so a sync seen during ADVANCE is kept pending
      // for the following ADVANCE rather than lost by the clear above.
      if (frame_sync && r_state != ST_CALIB) begin
        if (r_state == ST_FILL && r_beat == '0) begin
          if (r_word_ptr != '0) begin
            r_word_ptr   <= '0;
            r_sync_abort <= 1'b1;
          end
        end else begin
          r_sync_pend  <= 1'b1;
          r_sync_abort <= 1'b1;
        end
      end
    end
  end

  assign frame_done      = r_frame_done;
  assign write_buf       = w_write_buf;
  assign disp_buf        = w_disp_buf;
  assign sync_abort      = r_sync_abort;
  assign p_cmd_en        = r_cmd_en;
  assign p_cmd_instr     = MCB_CMD_WR;
  assign p_cmd_bl        = r_cmd_bl;
  assign p_cmd_byte_addr = r_cmd_addr;
  assign p_wr_en         = r_wr_en;
  assign p_wr_data       = r_wr_data;
  assign p_wr_mask       = '0;

endmodule

// File: tb/tb_mcb_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_mcb_frame_writer
// Self-checking bench for mcb_frame_writer with a small frame (64 words,
// 16-word bursts). Expected write data and command addresses are produced by
// a bench-side frame pointer model and queued; a negedge monitor pops and
// compares them as the DUT emits p_wr_en / p_cmd_en.
// Follows MCB_FRAME_DOUBLE_BUFFER_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mcb_frame_writer;

  localparam int DATA_W      = 32;
  localparam int BURST_LEN   = 16;
  localparam int FRAME_WORDS = 64;
  localparam int ADDR_W      = 30;
  localparam int FRAME0_BASE = 0;
  localparam int FRAME1_BASE = 4096;
  localparam int BPW         = 4;
`ifdef MCB_FRAME_DOUBLE_BUFFER_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                calib_done;
  logic                src_valid;
  logic [DATA_W-1:0]   src_data;
  logic                src_ready;
  logic                frame_sync;
  logic                frame_done;
  logic                write_buf;
  logic                disp_buf;
  logic                sync_abort;
  logic                p_cmd_full;
  logic                p_cmd_en;
  logic [2:0]          p_cmd_instr;
  logic [5:0]          p_cmd_bl;
  logic [ADDR_W-1:0]   p_cmd_byte_addr;
  logic                p_wr_full;
  logic                p_wr_en;
  logic [DATA_W-1:0]   p_wr_data;
  logic [DATA_W/8-1:0] p_wr_mask;

  mcb_frame_writer #(
    .DATA_W      (DATA_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_W      (ADDR_W),
    .FRAME0_BASE (FRAME0_BASE),
    .FRAME1_BASE (FRAME1_BASE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .calib_done      (calib_done),
    .src_valid       (src_valid),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .frame_sync      (frame_sync),
    .frame_done      (frame_done),
    .write_buf       (write_buf),
    .disp_buf        (disp_buf),
    .sync_abort      (sync_abort),
    .p_cmd_full      (p_cmd_full),
    .p_cmd_en        (p_cmd_en),
    .p_cmd_instr     (p_cmd_instr),
    .p_cmd_bl        (p_cmd_bl),
    .p_cmd_byte_addr (p_cmd_byte_addr),
    .p_wr_full       (p_wr_full),
    .p_wr_en         (p_wr_en),
    .p_wr_data       (p_wr_data),
    .p_wr_mask       (p_wr_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    bit                done;
  } cmd_exp_t;

  logic [DATA_W-1:0] wr_q[$];
  cmd_exp_t          cmd_q[$];
  int                checks   = 0;
  int                failures = 0;
  int                fd_seen  = 0;

  // Bench model of the frame pointer.
  int          m_ptr;
  int          m_beat;
  bit          m_buf;
  bit          m_disp;
  bit          m_pend;
  logic [31:0] pix = 32'd0;

  // ---------------------------------------------------------------- monitor
  logic [DATA_W-1:0] mon_exp;
  cmd_exp_t          mon_cmd;
  bit                done_due  = 1'b0;
  bit                prev_cmd  = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      done_due = 1'b0;
      prev_cmd = 1'b0;
    end else begin
      if (p_wr_en) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected: got data %h, expected no write", p_wr_data);
        end else begin
          mon_exp = wr_q.pop_front();
          if (p_wr_data !== mon_exp || p_wr_mask !== '0) begin
            failures++;
            $display("FAIL wr_data: got %h mask %h, expected %h mask 0", p_wr_data, p_wr_mask, mon_exp);
          end
        end
      end
      if (frame_done || done_due) begin
        checks++;
        if (frame_done !== done_due) begin
          failures++;
          $display("FAIL frame_done: got %b, expected %b", frame_done, done_due);
        end
      end
      if (frame_done) fd_seen++;
      done_due = 1'b0;
      if (p_cmd_en) begin
        checks++;
        if (prev_cmd) begin
          failures++;
          $display("FAIL cmd_pulse: p_cmd_en high on consecutive cycles, expected 1-cycle pulse");
        end else if (cmd_q.size() == 0) begin
          failures++;
          $display("FAIL cmd_unexpected: got addr %h, expected no command", p_cmd_byte_addr);
        end else begin
          mon_cmd = cmd_q.pop_front();
          done_due = mon_cmd.done;
          if (p_cmd_byte_addr !== mon_cmd.addr || p_cmd_bl !== 6'd15 ||
              p_cmd_instr !== 3'b000 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL cmd: got addr %h bl %0d instr %b pending_wr %0d, expected addr %h bl 15 instr 000 pending_wr 0",
                     p_cmd_byte_addr, p_cmd_bl, p_cmd_instr, wr_q.size(), mon_cmd.addr);
          end
        end
      end
      prev_cmd = p_cmd_en;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic model_end_burst();
    cmd_exp_t c;
    c.addr = ADDR_W'((m_buf ? FRAME1_BASE : FRAME0_BASE) + m_ptr * BPW);
    c.done = 1'b0;
    if (m_pend) begin
      m_ptr  = 0;
      m_pend = 1'b0;
    end else begin
      m_ptr += BURST_LEN;
      if (m_ptr == FRAME_WORDS) begin
        m_ptr  = 0;
        c.done = 1'b1;
        if (DBL) begin
          m_disp = m_buf;
          m_buf  = ~m_buf;
        end
      end
    end
    m_beat = 0;
    cmd_q.push_back(c);
  endtask

  // Presents one word (optionally with a frame_sync pulse) and waits for it
  // to be accepted; entered and left at a negedge.
  task automatic push_word(input logic [DATA_W-1:0] d, input bit sync);
    int waited = 0;
    src_valid  = 1'b1;
    src_data   = d;
    frame_sync = sync;
    #1;
    while (!src_ready && waited < 200) begin
      @(negedge clk);
      frame_sync = 1'b0;
      #1;
      waited++;
    end
    if (!src_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: src_ready stayed 0 for %0d cycles, expected 1", waited);
      src_valid = 1'b0;
    end else begin
      if (sync) begin
        if (m_beat != 0) m_pend = 1'b1;
        else if (m_ptr != 0) m_ptr = 0;
      end
      @(posedge clk);
      wr_q.push_back(d);
      m_beat++;
      if (m_beat == BURST_LEN) model_end_burst();
      @(negedge clk);
      src_valid  = 1'b0;
      frame_sync = 1'b0;
    end
  endtask

  task automatic send_burst(input int sync_at);
    for (int i = 0; i < BURST_LEN; i++) begin
      push_word(pix, i == sync_at);
      pix++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((wr_q.size() != 0 || cmd_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL drain_timeout: %0d writes and %0d commands outstanding, expected 0", wr_q.size(), cmd_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    calib_done = 1'b0;
    src_valid  = 1'b0;
    src_data   = '0;
    frame_sync = 1'b0;
    p_cmd_full = 1'b0;
    p_wr_full  = 1'b0;
    wr_q.delete();
    cmd_q.delete();
    m_ptr  = 0;
    m_beat = 0;
    m_buf  = 1'b0;
    m_disp = DBL;
    m_pend = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Raises calib_done and returns how many cycles src_ready took to rise.
  task automatic bring_up(output int lat);
    lat = 0;
    calib_done = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!src_ready && lat < 20);
    if (!src_ready) begin
      checks++;
      failures++;
      $display("FAIL calib_timeout: src_ready still 0 after %0d cycles, expected 1", lat);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({src_ready, p_wr_en, p_cmd_en, frame_done, sync_abort, write_buf} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy/wr/cmd/done/abort/wbuf=%b, expected 000000",
               {src_ready, p_wr_en, p_cmd_en, frame_done, sync_abort, write_buf});
    end
    checks++;
    if (disp_buf !== DBL) begin
      failures++;
      $display("FAIL reset_disp_buf: got %b, expected %b", disp_buf, DBL);
    end
    checks++;
    if (p_cmd_byte_addr !== '0 || p_cmd_bl !== '0 || p_cmd_instr !== '0 ||
        p_wr_data !== '0 || p_wr_mask !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr %h bl %0d instr %b data %h mask %h, expected all 0",
               p_cmd_byte_addr, p_cmd_bl, p_cmd_instr, p_wr_data, p_wr_mask);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_calib_gating();
    int bad = 0;
    int lat;
    src_valid  = 1'b1;
    src_data   = 32'hdead_beef;
    frame_sync = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (src_ready !== 1'b0 || p_wr_en !== 1'b0 || sync_abort !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL calib_gating: %0d cycles with ready/wr_en/abort set, expected 0", bad);
    end
    src_valid  = 1'b0;
    frame_sync = 1'b0;
    bring_up(lat);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL calib_latency: src_ready rose after %0d cycles, expected 3", lat);
    end
  endtask

  task automatic test_single_burst();
    send_burst(-1);   // data 0..15, command at 0
    drain();
    send_burst(-1);   // next command at 64
    drain();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      push_word(pix, 1'b0);
      pix++;
    end
    src_valid = 1'b1;
    src_data  = pix;
    p_wr_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (src_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wr_full_ready: src_ready high on %0d full cycles, expected 0", bad);
    end
    p_wr_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) p_cmd_full = 1'b1;
      push_word(pix, 1'b0);
      pix++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p_cmd_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL cmd_full_hold: p_cmd_en high on %0d cycles, expected 0", bad);
    end
    p_cmd_full = 1'b0;
    @(negedge clk);
    checks++;
    if (p_cmd_en !== 1'b1) begin
      failures++;
      $display("FAIL cmd_after_full: got p_cmd_en %b one cycle after full fell, expected 1", p_cmd_en);
    end
    drain();
  endtask

  task automatic test_frame_wrap();
    int lat;
    int fd0;
    apply_reset();
    reset = 1'b0;
    @(negedge clk);
    bring_up(lat);
    // Sync at the very start of a frame is a no-op.
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    @(negedge clk);
    checks++;
    if (sync_abort !== 1'b0) begin
      failures++;
      $display("FAIL sync_at_start: got sync_abort %b, expected 0", sync_abort);
    end
    for (int f = 0; f < 2; f++) begin
      fd0 = fd_seen;
      for (int b = 0; b < 4; b++) begin
        send_burst(-1);
        drain();
      end
      checks++;
      if (fd_seen - fd0 != 1 || write_buf !== m_buf || disp_buf !== m_disp) begin
        failures++;
        $display("FAIL frame_wrap%0d: got done_pulses %0d wbuf %b dbuf %b, expected 1 %b %b",
                 f, fd_seen - fd0, write_buf, disp_buf, m_buf, m_disp);
      end
    end
  endtask

  task automatic test_mid_frame_sync();
    int  fd0 = fd_seen;
    bit  wb0 = m_buf;
    send_burst(-1);
    drain();
    send_burst(5);    // sync on word 5 of burst 2: burst still lands at +64
    drain();
    checks++;
    if (sync_abort !== 1'b1) begin
      failures++;
      $display("FAIL sync_abort: got %b, expected 1", sync_abort);
    end
    send_burst(-1);   // restarted frame: back at +0, same buffer
    drain();
    // Sync between bursts with a non-zero pointer clears it at once.
    frame_sync = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    frame_sync = 1'b0;
    @(negedge clk);
    send_burst(-1);
    drain();
    checks++;
    if (fd_seen != fd0 || write_buf !== wb0) begin
      failures++;
      $display("FAIL sync_no_swap: got done_pulses %0d wbuf %b, expected 0 %b", fd_seen - fd0, write_buf, wb0);
    end
  endtask

  task automatic test_reset_in_issue();
    int lat;
    int bad = 0;
    for (int b = 0; b < 4; b++) begin
      send_burst(-1);
      drain();
    end
    p_cmd_full = 1'b1;
    send_burst(-1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({src_ready, p_wr_en, p_cmd_en, frame_done, sync_abort, write_buf} !== 6'b0 ||
        p_cmd_byte_addr !== '0 || p_cmd_bl !== '0 || p_wr_data !== '0 || disp_buf !== DBL) begin
      failures++;
      $display("FAIL reset_in_issue: got rdy/wr/cmd/done/abort/wbuf=%b addr %h bl %0d data %h dbuf %b, expected 000000 0 0 0 %b",
               {src_ready, p_wr_en, p_cmd_en, frame_done, sync_abort, write_buf},
               p_cmd_byte_addr, p_cmd_bl, p_wr_data, disp_buf, DBL);
    end
    apply_reset();
    calib_done = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (src_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_to_calib: src_ready high %0d cycles after reset, expected 0", bad);
    end
    bring_up(lat);
    send_burst(-1);   // pointer and buffer back at frame start
    drain();
  endtask

  initial begin
    test_reset();
    test_calib_gating();
    test_single_burst();
    test_backpressure();
    test_frame_wrap();
    test_mid_frame_sync();
    test_reset_in_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
